// File: rtl/tug_match_ctrl.sv
// Match/round controller for the tug-of-war playfield: gates presses, counts
// round wins, freezes the field after a round, and declares the match winner.
module tug_match_ctrl #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int TARGET      = 7
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       L_in,
    input  logic       R_in,
    input  logic       left_win,
    input  logic       right_win,
    output logic       L_out,
    output logic       R_out,
    output logic       field_reset,
    output logic [2:0] left_score,
    output logic [2:0] right_score,
    output logic       match_over,
    output logic       winner_left,
    output logic       winner_right,
    output logic [6:0] HEX_L,
    output logic [6:0] HEX_R
);

    typedef enum logic [1:0] {PLAY, HOLD, CLEAR, OVER} state_t;

    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
    localparam logic [2:0]  TARGET_S  = 3'(TARGET);

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [2:0]  lscore_nx, rscore_nx;
    logic        wl_nx, wr_nx;

    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= PLAY;
            cnt          <= '0;
            left_score   <= '0;
            right_score  <= '0;
            winner_left  <= 1'b0;
            winner_right <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            left_score   <= lscore_nx;
            right_score  <= rscore_nx;
            winner_left  <= wl_nx;
            winner_right <= wr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        lscore_nx = left_score;
        rscore_nx = right_score;
        wl_nx     = winner_left;
        wr_nx     = winner_right;
        case (state)
            PLAY: begin
                // A simultaneous win is a draw: replay the round with no score.
                if (left_win && right_win) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LOAD;
                end else if (left_win) begin
                    lscore_nx = left_score + 3'd1;
                    if (lscore_nx == TARGET_S) begin
                        state_nx = OVER;
                        wl_nx    = 1'b1;
                    end else begin
                        state_nx = HOLD;
                        cnt_nx   = HOLD_LOAD;
                    end
                end else if (right_win) begin
                    rscore_nx = right_score + 3'd1;
                    if (rscore_nx == TARGET_S) begin
                        state_nx = OVER;
                        wr_nx    = 1'b1;
                    end else begin
                        state_nx = HOLD;
                        cnt_nx   = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt == 32'd0) state_nx = CLEAR;
                else              cnt_nx   = cnt - 32'd1;
            end
            CLEAR:   state_nx = PLAY;
            default: state_nx = OVER;
        endcase
    end

    assign L_out       = L_in & (state == PLAY);
    assign R_out       = R_in & (state == PLAY);
    assign field_reset = (state == CLEAR);
    assign match_over  = (state == OVER);
    assign HEX_L       = seg7(left_score);
    assign HEX_R       = seg7(right_score);

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Directed bench for tug_match_ctrl with HOLD_CYCLES=4, TARGET=3.
module tb_tug_match_ctrl;

    logic clk = 1'b0;
    logic Reset, L_in, R_in, left_win, right_win;
    logic L_out, R_out, field_reset, match_over, winner_left, winner_right;
    logic [2:0] left_score, right_score;
    logic [6:0] HEX_L, HEX_R;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tug_match_ctrl #(.HOLD_CYCLES(4), .TARGET(3)) dut (
        .clk(clk), .Reset(Reset), .L_in(L_in), .R_in(R_in),
        .left_win(left_win), .right_win(right_win),
        .L_out(L_out), .R_out(R_out), .field_reset(field_reset),
        .left_score(left_score), .right_score(right_score),
        .match_over(match_over), .winner_left(winner_left),
        .winner_right(winner_right), .HEX_L(HEX_L), .HEX_R(HEX_R)
    );

    typedef struct {
        logic       rst, l, r, lw, rw;
        logic       el, er, efr;
        logic [2:0] els, ers;
        logic       emo, ewl, ewr;
    } vec_t;

    vec_t vq[$];
    logic [6:0] seg [8];

    task automatic add(input logic rst, l, r, lw, rw, el, er, efr,
                       input logic [2:0] els, ers, input logic emo, ewl, ewr);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.lw = lw; v.rw = rw;
        v.el = el; v.er = er; v.efr = efr; v.els = els; v.ers = ers;
        v.emo = emo; v.ewl = ewl; v.ewr = ewr;
        vq.push_back(v);
    endtask

    // n idle rows of frozen field, followed by the CLEAR row.
    task automatic add_hold_clear(input logic [2:0] ls, rs);
        for (int k = 0; k < 4; k++) add(0, 1, 1, 0, 0, 0, 0, 0, ls, rs, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 1, ls, rs, 0, 0, 0);
    endtask

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, l, r, lw, rw);
        @(negedge clk);
        Reset = rst; L_in = l; R_in = r; left_win = lw; right_win = rw;
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".L_out"},        7'(L_out),        7'(v.el));
        chk({tag, ".R_out"},        7'(R_out),        7'(v.er));
        chk({tag, ".field_reset"},  7'(field_reset),  7'(v.efr));
        chk({tag, ".left_score"},   7'(left_score),   7'(v.els));
        chk({tag, ".right_score"},  7'(right_score),  7'(v.ers));
        chk({tag, ".match_over"},   7'(match_over),   7'(v.emo));
        chk({tag, ".winner_left"},  7'(winner_left),  7'(v.ewl));
        chk({tag, ".winner_right"}, 7'(winner_right), 7'(v.ewr));
        chk({tag, ".HEX_L"},        HEX_L,            seg[v.els]);
        chk({tag, ".HEX_R"},        HEX_R,            seg[v.ers]);
    endtask

    initial begin
        seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100; seg[3] = 7'b0110000;
        seg[4] = 7'b0011001; seg[5] = 7'b0010010; seg[6] = 7'b0000010; seg[7] = 7'b1111000;
        Reset = 1'b1; L_in = 0; R_in = 0; left_win = 0; right_win = 0;

        // rst l r lw rw | L_out R_out fr | ls rs | mo wl wr
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // left round win
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // hold 1
        add(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // hold 2, win ignored
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);   // hold 3, win ignored
        add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);   // hold 4
        add(0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);   // clear, win ignored
        add(0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);   // play again
        add(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);   // draw
        add_hold_clear(1, 0);
        add(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);   // right win 1
        add_hold_clear(1, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0);   // right win 2
        add_hold_clear(1, 2);
        add(0, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0);   // right win 3 -> match
        for (int k = 0; k < 7; k++)
            add(0, 1, 1, k[0], ~k[0], 0, 0, 0, 1, 3, 1, 0, 1);

        repeat (2) @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].l, vq[i].r, vq[i].lw, vq[i].rw);
            chk_all($sformatf("vec%0d", i), vq[i]);
        end

        // Reset in the 2nd hold cycle aborts the round with no restart pulse.
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        chk("midhold.right_score", 7'(right_score), 7'd1);
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 0, 0);
            chk("midhold.L_out", 7'(L_out), 7'd1);
            chk("midhold.field_reset", 7'(field_reset), 7'd0);
            chk("midhold.scores", {1'b0, left_score, right_score}, 7'd0);
        end

        // Reset outranks a win in the same cycle.
        drive(1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        chk("rstprio.left_score", 7'(left_score), 7'd0);
        chk("rstprio.HEX_L", HEX_L, 7'b1000000);

        // Left player takes the match.
        for (int w = 0; w < 3; w++) begin
            drive(0, 0, 0, 1, 0);
            if (w < 2) repeat (5) drive(0, 0, 0, 0, 0);
        end
        drive(0, 1, 0, 0, 1);
        chk("leftmatch.match_over", 7'(match_over), 7'd1);
        chk("leftmatch.winner_left", 7'(winner_left), 7'd1);
        chk("leftmatch.winner_right", 7'(winner_right), 7'd0);
        chk("leftmatch.L_out", 7'(L_out), 7'd0);
        chk("leftmatch.HEX_L", HEX_L, 7'b0110000);
        drive(0, 0, 0, 0, 0);
        chk("leftmatch.right_score", 7'(right_score), 7'd0);
        chk("leftmatch.field_reset", 7'(field_reset), 7'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
